// File: rtl/grid_access_counter_if.sv
// Word stream into the grid access counter and its per-word / per-grid results.
interface grid_access_counter_if #(
  parameter int unsigned MODULAR_SIZE = 32,
  parameter int unsigned COUNT_WIDTH  = 16
);
  localparam int unsigned SLICE_W = MODULAR_SIZE + 2;
  localparam int unsigned WCNT_W  = $clog2(MODULAR_SIZE) + 1;

  logic               clear;
  logic               in_valid;
  logic               in_last;
  logic [SLICE_W-1:0] in_upper;
  logic [SLICE_W-1:0] in_middle;
  logic [SLICE_W-1:0] in_lower;

  logic                   out_word_valid;
  logic [WCNT_W-1:0]      out_word_count;
  logic [COUNT_WIDTH-1:0] out_total;
  logic                   out_overflow;
  logic                   out_done;

  modport master (
    output clear, in_valid, in_last, in_upper, in_middle, in_lower,
    input  out_word_valid, out_word_count, out_total, out_overflow, out_done
  );

  modport slave (
    input  clear, in_valid, in_last, in_upper, in_middle, in_lower,
    output out_word_valid, out_word_count, out_total, out_overflow, out_done
  );
endinterface

// File: rtl/grid_access_counter.sv
// Three-stage pipeline: flag low-neighbour cells, popcount per word,
// then accumulate a saturating grid total with sticky overflow/done.
module grid_access_counter #(
  parameter int unsigned MODULAR_SIZE = 32,
  parameter int unsigned COUNT_WIDTH  = 16,
  parameter int unsigned THRESHOLD    = 4
) (
  input logic                 clk,
  input logic                 reset_n,
  grid_access_counter_if.slave bus
);
  localparam int unsigned SLICE_W = MODULAR_SIZE + 2;
  localparam int unsigned WCNT_W  = $clog2(MODULAR_SIZE) + 1;
  localparam int unsigned SUM_W   = ((COUNT_WIDTH > WCNT_W) ? COUNT_WIDTH : WCNT_W) + 1;
  localparam logic [4:0]       THRESH_V  = 5'(THRESHOLD);
  localparam logic [SUM_W-1:0] TOTAL_MAX = SUM_W'({COUNT_WIDTH{1'b1}});

  logic [MODULAR_SIZE-1:0] flag_c;
  logic [WCNT_W-1:0]       pop_c;
  logic [SUM_W-1:0]        acc_sum_c;
  logic                    acc_sat_c;

  logic                    s1_valid;
  logic                    s1_last;
  logic [MODULAR_SIZE-1:0] s1_flags;
  logic                    s2_valid;
  logic                    s2_last;
  logic [WCNT_W-1:0]       s2_count;
  logic [COUNT_WIDTH-1:0]  total_q;
  logic                    overflow_q;
  logic                    done_q;

  // Halo bits only ever act as neighbours; centres are bits 1..MODULAR_SIZE.
  always_comb begin
    logic [3:0] nsum;
    flag_c = '0;
    nsum   = '0;
    for (int j = 1; j <= MODULAR_SIZE; j++) begin
      nsum = 4'(bus.in_upper[j-1]) + 4'(bus.in_upper[j]) + 4'(bus.in_upper[j+1])
           + 4'(bus.in_lower[j-1]) + 4'(bus.in_lower[j]) + 4'(bus.in_lower[j+1])
           + 4'(bus.in_middle[j-1]) + 4'(bus.in_middle[j+1]);
      flag_c[j-1] = bus.in_middle[j] && ({1'b0, nsum} < THRESH_V);
    end
  end

  always_comb begin
    pop_c = '0;
    for (int i = 0; i < MODULAR_SIZE; i++) begin
      pop_c = pop_c + WCNT_W'(s1_flags[i]);
    end
  end

  // Wide enough to hold the true sum so saturation is a simple compare.
  always_comb begin
    acc_sum_c = SUM_W'(total_q) + SUM_W'(s2_count);
    acc_sat_c = (acc_sum_c > TOTAL_MAX);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid   <= 1'b0;
      s1_last    <= 1'b0;
      s1_flags   <= '0;
      s2_valid   <= 1'b0;
      s2_last    <= 1'b0;
      s2_count   <= '0;
      total_q    <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else if (bus.clear) begin
      s1_valid   <= 1'b0;
      s2_valid   <= 1'b0;
      total_q    <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_flags <= flag_c;
        s1_last  <= bus.in_last;
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_count <= pop_c;
        s2_last  <= s1_last;
      end
      // Total freezes once the grid is done until the next clear.
      if (s2_valid && !done_q) begin
        if (acc_sat_c) begin
          total_q    <= COUNT_WIDTH'(TOTAL_MAX);
          overflow_q <= 1'b1;
        end else begin
          total_q <= COUNT_WIDTH'(acc_sum_c);
        end
        if (s2_last) begin
          done_q <= 1'b1;
        end
      end
    end
  end

  assign bus.out_word_valid = s2_valid;
  assign bus.out_word_count = s2_count;
  assign bus.out_total      = total_q;
  assign bus.out_overflow   = overflow_q;
  assign bus.out_done       = done_q;
endmodule

// File: tb/tb_grid_access_counter.sv
// Scoreboard bench for grid_access_counter at MODULAR_SIZE=8, COUNT_WIDTH=4.
module tb_grid_access_counter;
  localparam int unsigned MS = 8;
  localparam int unsigned CW = 4;

  typedef struct packed {
    logic [3:0] count;
    logic       last;
  } exp_t;

  logic clk;
  logic reset_n;
  int   errors = 0;
  int   checks = 0;

  exp_t       exp_q[$];
  logic [3:0] m_total;
  logic       m_ovf;
  logic       m_done;

  grid_access_counter_if #(.MODULAR_SIZE(MS), .COUNT_WIDTH(CW)) bus ();

  grid_access_counter #(.MODULAR_SIZE(MS), .COUNT_WIDTH(CW), .THRESHOLD(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: count set centres with fewer than 4 of their 8 neighbours set.
  function automatic logic [3:0] model_count(input logic [9:0] u, input logic [9:0] m,
                                             input logic [9:0] l);
    int c;
    int n;
    c = 0;
    for (int j = 1; j <= 8; j++) begin
      n = int'(u[j-1]) + int'(u[j]) + int'(u[j+1]) + int'(l[j-1]) + int'(l[j])
        + int'(l[j+1]) + int'(m[j-1]) + int'(m[j+1]);
      if (m[j] && n < 4) c++;
    end
    return 4'(c);
  endfunction

  task automatic drive(input logic v, input logic [9:0] u, input logic [9:0] m,
                       input logic [9:0] l, input logic last, input logic clr);
    exp_t e;
    @(posedge clk);
    #1;
    bus.in_valid  = v;
    bus.in_upper  = u;
    bus.in_middle = m;
    bus.in_lower  = l;
    bus.in_last   = last;
    bus.clear     = clr;
    if (v && !clr) begin
      e.count = model_count(u, m, l);
      e.last  = last;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic do_clear();
    drive(1'b0, '0, '0, '0, 1'b0, 1'b1);
    idle(1);
  endtask

  // Monitor: compare totals against the model every cycle, pop on each word.
  always @(negedge clk) begin
    exp_t e;
    int   s;
    if (!reset_n) begin
      exp_q.delete();
      m_total = '0;
      m_ovf   = 1'b0;
      m_done  = 1'b0;
    end else begin
      check("total", 32'(bus.out_total), 32'(m_total));
      check("overflow", 32'(bus.out_overflow), 32'(m_ovf));
      check("done", 32'(bus.out_done), 32'(m_done));
      if (bus.out_word_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_word_valid", 32'(bus.out_word_valid), 32'(0));
        end else begin
          e = exp_q.pop_front();
          check("word_count", 32'(bus.out_word_count), 32'(e.count));
          if (!bus.clear && !m_done) begin
            s = int'(m_total) + int'(e.count);
            if (s > 15) begin
              m_total = 4'hF;
              m_ovf   = 1'b1;
            end else begin
              m_total = 4'(s);
            end
            if (e.last) m_done = 1'b1;
          end
        end
      end
      if (bus.clear) begin
        exp_q.delete();
        m_total = '0;
        m_ovf   = 1'b0;
        m_done  = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    logic [9:0] full;
    logic [9:0] row8;
    logic [9:0] one;
    logic [9:0] five;
    full = 10'h3FF;
    row8 = 10'b0111111110;
    one  = 10'b0000100000;
    five = 10'b0111110000;

    reset_n       = 1'b0;
    bus.clear     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.in_upper  = '0;
    bus.in_middle = '0;
    bus.in_lower  = '0;
    #1;
    check("reset_total", 32'(bus.out_total), 32'(0));
    check("reset_word_valid", 32'(bus.out_word_valid), 32'(0));
    check("reset_done", 32'(bus.out_done), 32'(0));
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;

    // Single full row, no vertical neighbours: every cell accessible.
    drive(1'b1, '0, row8, '0, 1'b1, 1'b0);
    idle(4);
    check("row8_total", 32'(bus.out_total), 32'(8));
    check("row8_done", 32'(bus.out_done), 32'(1));

    // Fully surrounded cells are never accessible.
    do_clear();
    drive(1'b1, full, full, full, 1'b1, 1'b0);
    idle(4);
    check("full_total", 32'(bus.out_total), 32'(0));

    // Single centre with 3 then 6 neighbours.
    do_clear();
    drive(1'b1, full, one, '0, 1'b0, 1'b0);
    drive(1'b1, full, one, full, 1'b1, 1'b0);
    idle(4);
    check("one_total", 32'(bus.out_total), 32'(1));

    // Saturation: 8 + 8 + 8 into 4 bits, then words after done are ignored.
    do_clear();
    drive(1'b1, '0, row8, '0, 1'b0, 1'b0);
    drive(1'b1, '0, row8, '0, 1'b0, 1'b0);
    drive(1'b1, '0, row8, '0, 1'b1, 1'b0);
    drive(1'b1, '0, one, '0, 1'b1, 1'b0);
    idle(4);
    check("sat_total", 32'(bus.out_total), 32'(15));
    check("sat_overflow", 32'(bus.out_overflow), 32'(1));
    idle(3);
    check("sat_overflow_sticky", 32'(bus.out_overflow), 32'(1));

    // Clear with the third word discards words 1..3.
    do_clear();
    drive(1'b1, '0, row8, '0, 1'b0, 1'b0);
    drive(1'b1, '0, row8, '0, 1'b0, 1'b0);
    drive(1'b1, '0, row8, '0, 1'b0, 1'b1);
    drive(1'b1, full, one, '0, 1'b1, 1'b0);
    idle(4);
    check("clear_mid_total", 32'(bus.out_total), 32'(1));
    check("clear_mid_done", 32'(bus.out_done), 32'(1));

    // Random back-to-back words.
    do_clear();
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 10'($urandom), 10'($urandom), 10'($urandom), 1'(k == 19), 1'b0);
    end
    idle(4);

    // Asynchronous reset with total 5 and two words in flight.
    do_clear();
    drive(1'b1, '0, five, '0, 1'b0, 1'b0);
    idle(3);
    drive(1'b1, '0, row8, '0, 1'b0, 1'b0);
    drive(1'b1, '0, row8, '0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    bus.in_valid = 1'b0;
    check("pre_reset_total", 32'(bus.out_total), 32'(5));
    check("pre_reset_inflight", 32'(bus.out_word_valid), 32'(1));
    reset_n = 1'b0;
    #1;
    check("async_total", 32'(bus.out_total), 32'(0));
    check("async_word_valid", 32'(bus.out_word_valid), 32'(0));
    check("async_overflow", 32'(bus.out_overflow), 32'(0));
    check("async_done", 32'(bus.out_done), 32'(0));
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      check("post_reset_word_valid", 32'(bus.out_word_valid), 32'(0));
    end

    // Grid restart after reset without clear.
    drive(1'b1, full, one, '0, 1'b1, 1'b0);
    idle(4);
    check("restart_total", 32'(bus.out_total), 32'(1));
    check("drain", 32'(exp_q.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/grid_access_counter.md
# grid_access_counter

- Counts accessible cells in a binary grid, one word per cycle.
- Sits directly downstream of the row register stage, which presents each row as MODULAR_SIZE-bit words with one halo bit on each side.
- For every word it takes the upper, middle and lower row slices and flags each set middle cell with fewer than THRESHOLD set neighbours (of 8).
- It popcounts the flags per word and accumulates a saturating grid total, with a done indication on the last word.

## Interface
- MODULAR_SIZE, 32, cells per word; slices are MODULAR_SIZE+2 bits.
- COUNT_WIDTH, 16, width of the running total.
- THRESHOLD, 4, a cell is accessible when its neighbour count is strictly less than this value.
- clk  input  1  single clock; all state changes on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous start-of-grid clear.
- in_valid  input  1  the three slices and in_last are valid this cycle.
- in_last  input  1  this word is the final word of the grid.
- in_upper  input  MODULAR_SIZE+2  row above; bit MODULAR_SIZE+1 is the left halo, bit 0 is the right halo.
- in_middle  input  MODULAR_SIZE+2  current row, same layout.
- in_lower  input  MODULAR_SIZE+2  row below, same layout.
- out_word_valid  output  1  out_word_count is valid this cycle.
- out_word_count  output  $clog2(MODULAR_SIZE)+1  number of accessible cells in one word.
- out_total  output  COUNT_WIDTH  running grid total; saturates.
- out_overflow  output  1  sticky; the total has saturated.
- out_done  output  1  sticky; the last word has been accumulated.

## Operation
- Cell j (j = 1..MODULAR_SIZE) is in_middle[j].
  - Upper neighbours: in_upper[j-1], in_upper[j], in_upper[j+1].
  - Lower neighbours: in_lower[j-1], in_lower[j], in_lower[j+1].
  - Side neighbours: in_middle[j-1], in_middle[j+1].
- Neighbour sum is 4 bits, range 0..8. flag[j] = in_middle[j] && (sum < THRESHOLD).
- Halo bits are never centres. Cells beyond the grid width arrive as 0 and are never counted.
- Stage 1 registers the flag vector and the last bit, qualified by in_valid.
- Stage 2 registers the popcount of the flags into out_word_count. out_word_valid goes high the same cycle.
- Stage 3 accumulates when stage 2 is valid and out_done = 0.
  - out_total <= out_total + out_word_count, zero-extended.
  - If the true sum exceeds 2^COUNT_WIDTH-1, out_total saturates at all ones and out_overflow is set.
  - If the accumulated word carried last, out_done is set.
- Once out_done = 1, further words still produce out_word_valid/out_word_count but do not change out_total. The block then waits for clear.
- clear:
  - Zeroes out_total, out_overflow and out_done.
  - Drops all pipeline valid bits, so in-flight words are discarded.
  - A word presented with in_valid in the same cycle as clear is also discarded.
- No backpressure: one word per cycle, sustained, with no bubbles required.

## Timing
- Reset (reset_n low, asynchronous): all outputs and pipeline valids go to 0 immediately and stay 0 until the first posedge after release.
- Reset mid-grid: all partial results are lost. Upstream must restart the grid; clear is not required after reset.
- Word accepted at edge E:
  - out_word_valid/out_word_count are visible after edge E+1, for one cycle per word.
  - out_total and out_done are visible after edge E+2.
- Back-to-back words give consecutive out_word_valid pulses; the total advances by one word per cycle.
- in_valid with in_last when out_done is already 1 has no effect on the total.
- clear at edge C: out_total = 0 after C. A word at edge C+1 is accepted normally.

## Test plan
- MODULAR_SIZE=8: middle=0_11111111_0, upper=lower=0 -> out_word_count=8 two cycles later; out_total=8 and out_done=1 one cycle after that (in_last=1).
- All three slices = 10'h3FF -> every centre has 8 neighbours -> out_word_count=0, out_total=0.
- Middle=10'b0000100000, upper=10'h3FF, lower=0 -> centre has 3 neighbours -> count=1. Repeat with lower=10'h3FF -> 6 neighbours -> count=0.
- COUNT_WIDTH=4, three back-to-back words of count 8 -> totals 8 then 15, out_overflow=1 and stays 1 until clear.
- Stream of 4 words with clear asserted together with the 3rd word -> words 1, 2 and 3 are discarded, out_total equals word 4's count only.
- reset_n pulsed low while out_total=5 and two words are in flight -> all outputs are 0 asynchronously; no stale out_word_valid after release.
